mag_i2c_reader: RTL
===================

# mag_i2c_reader

I2C master that fetches one magnetometer sample (X, Y, Z, 16-bit each) per request and hands the assembled 48-bit vector to `mag_data_handling`. It sits between the board I2C pins and `mag_data_handling`. It issues a register-pointer write, a repeated start, and a 6-byte burst read. It then reorders the device byte order into a fixed X,Y,Z word and strobes it out.

## Interface
- `CLK_DIV`, 120, clock cycles per quarter SCL period; 120 gives 100 kHz SCL from 48 MHz; legal range 2..1023.
- `DEV_ADDR`, 7'h1E, 7-bit magnetometer slave address.
- `DATA_REG`, 8'h03, first data register (X_H); the device auto-increments.
- `CLK_48MHZ` in 1: the single clock; all logic is on its rising edge.
- `RESET` in 1: asynchronous, active-high reset.
- `START` in 1: one-cycle read request; ignored while `BUSY`=1.
- `SDA_IN` in 1: sampled SDA pad; already synchronised externally.
- `SCL_OE` out 1: 1 pulls SCL low, 0 releases it.
- `SDA_OE` out 1: 1 pulls SDA low, 0 releases it.
- `MDATA` out 48: {X[15:0], Y[15:0], Z[15:0]}, two's complement, held until the next good read.
- `MDATA_VALID` out 1: one-cycle pulse when `MDATA` updates.
- `BUSY` out 1: high while a transaction is in progress.
- `NACK_ERR` out 1: one-cycle pulse when a transaction is aborted by a slave NACK.

## Operation
- **States:**
  - IDLE → START_C → WR_BYTE (0x3C) → WR_ACK → WR_BYTE (`DATA_REG`) → WR_ACK.
  - Then RSTART → WR_BYTE (0x3D) → WR_ACK → RD_BYTE → RD_ACK, repeated 6×, → STOP_C → DONE → IDLE.
- **Bit slot:** every bit slot is 4 quarters of `CLK_DIV` cycles each, driven by a quarter counter and a 2-bit phase.
  - Data and ACK slots: Q0 SCL low, SDA updated at Q0 entry; Q1–Q2 SCL released; Q3 SCL low.
  - SDA is sampled on the last cycle of Q1.
- **Start slot:** Q0–Q1 both lines released; Q2 SDA low; Q3 SCL low.
- **Repeated start slot:** Q0 SCL low with SDA released; Q1 SCL released; Q2 SDA low; Q3 SCL low.
- **Stop slot:** Q0 SCL and SDA low; Q1 SCL released; Q2–Q3 SDA released.
- **Byte order:** bytes are shifted MSB first.
- **Write ACKs:** in WR_ACK, SDA is released. Sampled SDA_IN=1 means NACK: go to STOP_C, then assert `NACK_ERR` in DONE instead of `MDATA_VALID`.
- **Read ACKs:** in RD_ACK the master drives ACK (SDA low) after bytes 1–5 and NACK (released) after byte 6.
- **Received bytes:** the device order is X_H, X_L, Z_H, Z_L, Y_H, Y_L. They are loaded into a staging register, and `MDATA` is written from it only in DONE on a good transaction.
- **Clock stretching:** none; SCL is never read back.
- **Reset (any state):** all state clears immediately.
  - `SCL_OE`=0, `SDA_OE`=0, `MDATA`=0, `MDATA_VALID`=0, `BUSY`=0, `NACK_ERR`=0.
  - The state machine returns to IDLE and the counters go to 0.
  - A reset mid-transaction abandons the bus with no STOP; the next START regenerates a full sequence.

## Timing
- `START` is sampled in IDLE on cycle N; `BUSY`=1 from N+1.
- A complete transaction is 84 bit slots: start 1 + 2×9 write, RSTART 1 + 9 address read, 6×9 data, stop 1.
- `MDATA`/`MDATA_VALID` (or `NACK_ERR`) are asserted on cycle N+1+84·4·`CLK_DIV`. With the default divider that is N+40321.
- `BUSY` falls the cycle after the DONE pulse.
- A `START` arriving in the DONE cycle or while `BUSY`=1 is dropped, not queued.
- A NACK aborts into the stop slot immediately after the ACK slot.
  - NACK on the first address byte: `NACK_ERR` at N+1+(1+9+1)·4·`CLK_DIV`.
- SDA never changes while SCL is released, except in start, repeated start and stop slots.

## Test plan
- **Reset:** assert `RESET` mid-read-byte → all outputs 0 in the same cycle and both lines released; after release, `START` yields a fresh START_C.
- **Nominal read (`CLK_DIV`=2, behavioural slave at 0x1E):**
  - Slave ACKs and returns 12 34 56 78 9A BC.
  - `MDATA`=48'h1234_9ABC_5678, `MDATA_VALID` one cycle at N+673, `NACK_ERR`=0.
- **Address NACK:** slave absent → `NACK_ERR` pulse at N+89, STOP generated, `MDATA` unchanged from the prior value.
- **Register NACK:** slave NACKs `DATA_REG` → STOP after the second ACK slot, `NACK_ERR`=1, no repeated start seen.
- **Busy drop:** `START` re-pulsed while `BUSY`=1 and in the DONE cycle → exactly one transaction on the bus.
- **Bus protocol:** monitor checks that SDA is stable while SCL is high outside start/stop slots, that the master ACK count is 5, and that the final NACK is present.

Source files
------------

// File: rtl/mag_i2c_reader_if.sv
// Pin-side and result signals of the magnetometer I2C reader, grouped so the
// reader and its consumer share one bundle.
interface mag_i2c_reader_if;
  logic        i_start;
  logic        i_sda_in;
  logic        o_scl_oe;
  logic        o_sda_oe;
  logic [47:0] o_mdata;
  logic        o_mdata_valid;
  logic        o_busy;
  logic        o_nack_err;

  modport master (
    input  i_start, i_sda_in,
    output o_scl_oe, o_sda_oe, o_mdata, o_mdata_valid, o_busy, o_nack_err
  );

  modport slave (
    output i_start, i_sda_in,
    input  o_scl_oe, o_sda_oe, o_mdata, o_mdata_valid, o_busy, o_nack_err
  );
endinterface

// File: rtl/mag_i2c_reader.sv
// I2C master: register-pointer write, repeated start, 6-byte burst read of one
// magnetometer sample, reordered into {X, Y, Z} and strobed out.
module mag_i2c_reader #(
  parameter int unsigned CLK_DIV  = 120,
  parameter logic [6:0]  DEV_ADDR = 7'h1E,
  parameter logic [7:0]  DATA_REG = 8'h03
) (
  input logic              clk,
  input logic              rst,
  mag_i2c_reader_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_START_C, S_WR_BYTE, S_WR_ACK, S_RSTART,
    S_RD_BYTE, S_RD_ACK, S_STOP_C, S_DONE
  } state_t;

  localparam logic [9:0] QLAST = 10'(CLK_DIV - 1);

  state_t      r_state, w_next;
  logic [9:0]  r_qcnt;
  logic [1:0]  r_phase;
  logic [2:0]  r_bitcnt;
  logic [2:0]  r_bytecnt;
  logic [7:0]  r_tx;
  logic [47:0] r_rx;
  logic [47:0] r_mdata;
  logic        r_ackbit;
  logic        r_nack;
  logic        w_run, w_qend, w_slot_end, w_sample, w_scl_edge;
  logic        w_scl_oe, w_sda_oe;

  assign w_run      = (r_state != S_IDLE) && (r_state != S_DONE);
  assign w_qend     = w_run && (r_qcnt == QLAST);
  assign w_slot_end = w_qend && (r_phase == 2'd3);
  assign w_sample   = w_qend && (r_phase == 2'd1);
  assign w_scl_edge = (r_phase == 2'd0) || (r_phase == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (bus.i_start) w_next = S_START_C;
      S_START_C,
      S_RSTART:  if (w_slot_end) w_next = S_WR_BYTE;
      S_WR_BYTE: if (w_slot_end && r_bitcnt == 3'd7) w_next = S_WR_ACK;
      S_WR_ACK: begin
        if (w_slot_end) begin
          if (r_ackbit)                w_next = S_STOP_C;
          else if (r_bytecnt == 3'd0)  w_next = S_WR_BYTE;
          else if (r_bytecnt == 3'd1)  w_next = S_RSTART;
          else                         w_next = S_RD_BYTE;
        end
      end
      S_RD_BYTE: if (w_slot_end && r_bitcnt == 3'd7) w_next = S_RD_ACK;
      S_RD_ACK: begin
        if (w_slot_end) w_next = (r_bytecnt == 3'd5) ? S_STOP_C : S_RD_BYTE;
      end
      S_STOP_C:  if (w_slot_end) w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Quarter counter and phase stay at zero outside a transaction so every
  // transaction (including one after an abandoning reset) starts on Q0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_qcnt  <= '0;
      r_phase <= '0;
    end else if (!w_run) begin
      r_qcnt  <= '0;
      r_phase <= '0;
    end else if (w_qend) begin
      r_qcnt  <= '0;
      r_phase <= r_phase + 2'd1;
    end else begin
      r_qcnt  <= r_qcnt + 10'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bitcnt  <= '0;
      r_bytecnt <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_ackbit  <= 1'b0;
      r_nack    <= 1'b0;
      r_mdata   <= '0;
    end else begin
      if (r_state == S_IDLE && bus.i_start) begin
        r_tx      <= {DEV_ADDR, 1'b0};
        r_bitcnt  <= '0;
        r_bytecnt <= '0;
        r_nack    <= 1'b0;
      end
      if (w_sample) begin
        if (r_state == S_WR_ACK)  r_ackbit <= bus.i_sda_in;
        if (r_state == S_RD_BYTE) r_rx     <= {r_rx[46:0], bus.i_sda_in};
      end
      if (w_slot_end) begin
        case (r_state)
          S_WR_BYTE: begin
            r_tx     <= {r_tx[6:0], 1'b0};
            r_bitcnt <= r_bitcnt + 3'd1;
          end
          S_RD_BYTE: r_bitcnt <= r_bitcnt + 3'd1;
          S_WR_ACK: begin
            if (r_ackbit) begin
              r_nack <= 1'b1;
            end else if (r_bytecnt == 3'd0) begin
              r_tx      <= DATA_REG;
              r_bytecnt <= 3'd1;
            end else if (r_bytecnt == 3'd1) begin
              r_tx      <= {DEV_ADDR, 1'b1};
              r_bytecnt <= 3'd2;
            end else begin
              r_bytecnt <= 3'd0;
            end
          end
          S_RD_ACK: r_bytecnt <= r_bytecnt + 3'd1;
          // Loaded on the edge into DONE so MDATA is already new while VALID pulses.
          // Device order is X_H X_L Z_H Z_L Y_H Y_L; output order is X, Y, Z.
          S_STOP_C: if (!r_nack) r_mdata <= {r_rx[47:32], r_rx[15:0], r_rx[31:16]};
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_scl_oe = 1'b0;
    w_sda_oe = 1'b0;
    case (r_state)
      S_START_C: begin
        w_sda_oe = r_phase[1];
        w_scl_oe = (r_phase == 2'd3);
      end
      S_RSTART: begin
        w_sda_oe = r_phase[1];
        w_scl_oe = w_scl_edge;
      end
      S_STOP_C: begin
        w_sda_oe = ~r_phase[1];
        w_scl_oe = (r_phase == 2'd0);
      end
      S_WR_BYTE: begin
        w_sda_oe = ~r_tx[7];
        w_scl_oe = w_scl_edge;
      end
      // Master ACKs bytes 1-5 and leaves the line released (NACK) after byte 6.
      S_RD_ACK: begin
        w_sda_oe = (r_bytecnt != 3'd5);
        w_scl_oe = w_scl_edge;
      end
      S_WR_ACK, S_RD_BYTE: w_scl_oe = w_scl_edge;
      default: ;
    endcase
  end

  assign bus.o_scl_oe      = w_scl_oe;
  assign bus.o_sda_oe      = w_sda_oe;
  assign bus.o_mdata       = r_mdata;
  assign bus.o_mdata_valid = (r_state == S_DONE) && !r_nack;
  assign bus.o_nack_err    = (r_state == S_DONE) && r_nack;
  assign bus.o_busy        = (r_state != S_IDLE);

endmodule
